cell_draw_fsm: RTL
==================

// Module: cell_draw_fsm
// PURPOSE
//  Consumes a grid cell position (6-bit column / 4-bit row from the position counters) and a colour.
//  Emits one plot beat per pixel of a CELL_W x CELL_H filled block in raster order.
//  Sits between the position counters and the VGA adapter's pixel write port; downstream may stall.
// PARAMETERS
//  CELL_W   4  block width in pixels (1..16)
//  CELL_H   4  block height in pixels (1..16)
//  X_W      8  pixel x coordinate width
//  Y_W      7  pixel y coordinate width
//  COLOR_W  3  colour width
// PORTS
//  CLK         in   1        clock, all state on posedge
//  CLR         in   1        synchronous active-high reset
//  start       in   1        draw request; accepted only when busy=0
//  col         in   6        cell column, sampled with start
//  row         in   4        cell row, sampled with start
//  colour      in   COLOR_W  fill colour, sampled with start
//  erase       in   1        sampled with start; 1 forces colour_out=0 for the whole block
//  plot_ready  in   1        downstream accepts the current beat
//  plot        out  1        beat valid
//  x_out       out  X_W      beat pixel x
//  y_out       out  Y_W      beat pixel y
//  colour_out  out  COLOR_W  beat colour
//  busy        out  1        high in DRAW and DONE
//  done        out  1        one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: CLR=1 at an edge -> state IDLE; plot, busy, done, x_out, y_out, colour_out, dx, dy all 0.
//   CLR wins over every other input, including a simultaneous start.
//   CLR mid-draw aborts: no remaining beats, no done pulse.
//  States: IDLE -> DRAW -> DONE -> IDLE.
//  IDLE: start=1 at an edge -> latch ox=(col*CELL_W) mod 2^X_W, oy=(row*CELL_H) mod 2^Y_W.
//   Also latch colour (or 0 if erase=1); dx=dy=0; go to DRAW.
//  DRAW: plot=1; x_out=ox+dx, y_out=oy+dy (truncated to X_W/Y_W); busy=1.
//   Beat accepted when plot & plot_ready at an edge.
//   On accept: if dx<CELL_W-1 then dx+1; else dx=0, dy+1.
//   Accept of dx=CELL_W-1, dy=CELL_H-1 -> DONE.
//   plot_ready=0 holds x_out/y_out/colour_out stable; plot stays 1.
//  DONE: plot=0, busy=1, done=1 for exactly one cycle; next edge -> IDLE.
//  Latency: start sampled at edge k -> first beat valid in the cycle after k.
//   No-stall draw spans CELL_W*CELL_H cycles; done occurs in cycle k+CELL_W*CELL_H+1.
//  start while busy=1 (DRAW or DONE) is ignored, not queued; col/row/colour/erase changes mid-draw have no effect.
//  dx/dy counters are 4 bits; x/y adds wrap modulo 2^X_W / 2^Y_W, never saturate.
//  Outputs registered; no combinational path from plot_ready to plot.
// TESTING
//  1 CLR=1 with start=1 -> after edge, plot=busy=done=0, x_out=y_out=0; no draw follows.
//  2 start, col=3,row=2,colour=5, plot_ready=1 -> 16 beats, (12,8)..(15,8),(12,9)..(15,11), colour 5; done 1 cycle; busy=0 after.
//  3 Same as 2, plot_ready low 3 cycles at beat 6 -> beat (13,9) held stable 3 cycles; 16 beats total, no repeats/skips.
//  4 col=63,row=15,erase=1,colour=7 -> x 252..255, y 60..63, colour_out=0 throughout.
//  5 start pulsed during DRAW and DONE with col=0,row=0 -> ignored; only the first block is drawn.
//  6 CLR asserted at beat 5 -> next cycle IDLE, plot=0, no done; a new start then draws normally from dx=dy=0.

Source files
------------

// File: rtl/cell_draw_fsm.sv
// Purpose: rasterises one CELL_W x CELL_H filled block per accepted start into a stream of pixel plot beats.
// Latency: first beat valid the cycle after start is sampled; done pulses one cycle after the last beat is accepted.
// Backpressure: plot_ready=0 holds the current beat (plot, x_out, y_out, colour_out) stable until accepted.
//
// Ports:
//   CLK, CLR          clock and synchronous active-high reset
//   start             draw request, honoured only while busy=0
//   col, row          cell position, sampled with start
//   colour, erase     fill colour, sampled with start (erase forces colour 0)
//   plot_ready        downstream accepts the current beat
//   plot              beat valid
//   x_out, y_out      beat pixel coordinate
//   colour_out        beat colour
//   busy              high while drawing or signalling done
//   done              one-cycle completion pulse
module cell_draw_fsm #(
   parameter int CELL_W  = 4,
   parameter int CELL_H  = 4,
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int COLOR_W = 3
) (
   input  logic               CLK,
   input  logic               CLR,
   input  logic               start,
   input  logic [5:0]         col,
   input  logic [3:0]         row,
   input  logic [COLOR_W-1:0] colour,
   input  logic               erase,
   input  logic               plot_ready,
   output logic               plot,
   output logic [X_W-1:0]     x_out,
   output logic [Y_W-1:0]     y_out,
   output logic [COLOR_W-1:0] colour_out,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [X_W-1:0] CW      = X_W'(CELL_W);
   localparam logic [Y_W-1:0] CH      = Y_W'(CELL_H);
   localparam logic [3:0]     DX_LAST = 4'(CELL_W - 1);
   localparam logic [3:0]     DY_LAST = 4'(CELL_H - 1);

   state_t             state_q, state_d;
   logic [X_W-1:0]     ox_q, ox_d;
   logic [Y_W-1:0]     oy_q, oy_d;
   logic [3:0]         dx_q, dx_d;
   logic [3:0]         dy_q, dy_d;
   logic               plot_q, plot_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [COLOR_W-1:0] colour_out_q, colour_out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // All outputs are computed one cycle ahead and registered, so plot_ready
   // only ever reaches the outputs through a flop.
   always_comb begin
      state_d      = state_q;
      ox_d         = ox_q;
      oy_d         = oy_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      plot_d       = plot_q;
      x_d          = x_q;
      y_d          = y_q;
      colour_out_d = colour_out_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            plot_d = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               state_d      = S_DRAW;
               // Products are truncated to the coordinate width: wrap, never saturate.
               ox_d         = X_W'(col) * CW;
               oy_d         = Y_W'(row) * CH;
               dx_d         = '0;
               dy_d         = '0;
               x_d          = ox_d;
               y_d          = oy_d;
               colour_out_d = erase ? '0 : colour;
               plot_d       = 1'b1;
               busy_d       = 1'b1;
            end
         end

         S_DRAW: begin
            if (plot_ready) begin
               if (dx_q != DX_LAST) begin
                  dx_d = dx_q + 4'd1;
               end else begin
                  dx_d = '0;
                  dy_d = dy_q + 4'd1;
               end
               if (dx_q == DX_LAST && dy_q == DY_LAST) begin
                  // Last beat accepted: coordinates keep their final value.
                  state_d = S_DONE;
                  dy_d    = '0;
                  plot_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  x_d = ox_q + X_W'(dx_d);
                  y_d = oy_q + Y_W'(dy_d);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            plot_d  = 1'b0;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            plot_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q      <= S_IDLE;
         ox_q         <= '0;
         oy_q         <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         plot_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         colour_out_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ox_q         <= ox_d;
         oy_q         <= oy_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         plot_q       <= plot_d;
         x_q          <= x_d;
         y_q          <= y_d;
         colour_out_q <= colour_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign plot       = plot_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour_out = colour_out_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
